// File: rtl/sdma_pkg.sv
// Shared definitions for the streaming DMA front end: default sizing and
// the 2-bit encodings of the request FSM.
package sdma_pkg;

    localparam int SDMA_DATA_WIDTH = 32;
    localparam int SDMA_DEPTH      = 16;
    localparam int SDMA_BURST      = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_DONE   = 2'd3
    } sdma_state_e;

endpackage

// File: rtl/sdma_fifo.sv
// Power-of-two stream FIFO with a registered read port, occupancy count and
// sticky overflow/underflow flags.
module sdma_fifo
    import sdma_pkg::*;
#(
    parameter int DATA_WIDTH = SDMA_DATA_WIDTH,
    parameter int DEPTH      = SDMA_DEPTH,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_valid,
    output logic                  ready,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [AW:0]           level,
    output logic                  ovf,
    output logic                  unf,
    input  logic                  err_clr
);

    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [AW:0]           level_q, level_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
    logic                  full, empty, push, pop;

    assign full  = (level_q == FULL_LEVEL);
    assign empty = (level_q == '0);
    assign push  = wr_valid && !full;
    assign pop   = rd_en && !empty;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        rd_data_d = rd_data_q;
        level_d   = level_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;

        // Pointers are exactly AW bits, so the increment wraps DEPTH-1 -> 0.
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop) begin
            rd_ptr_d  = rd_ptr_q + 1'b1;
            rd_data_d = mem[rd_ptr_q];
        end

        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        // Clear first so a same-cycle error event wins over err_clr.
        if (err_clr) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end
        if (wr_valid && full) ovf_d = 1'b1;
        if (rd_en && empty)   unf_d = 1'b1;
    end

    // NOTE: the storage array has no reset so it maps onto RAM; pointers and level alone say which words are valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= wr_data;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples the pre-edge values.
        if (!rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            rd_data_q <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            rd_data_q <= rd_data_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
        end
    end

    assign ready   = !full;
    assign rd_data = rd_data_q;
    assign level   = level_q;
    assign ovf     = ovf_q;
    assign unf     = unf_q;

endmodule

// File: rtl/sdma_stream.sv
// Stream-to-DMA bridge: buffers producer words and raises a DMA request
// once a burst is available, pulsing an interrupt when the transfer ends.
module sdma_stream
    import sdma_pkg::*;
#(
    parameter int DATA_WIDTH = SDMA_DATA_WIDTH,
    parameter int DEPTH      = SDMA_DEPTH,
    parameter int BURST      = SDMA_BURST,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  valid,
    output logic                  ready,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [AW:0]           level,
    output logic                  sdma_req,
    input  logic                  sdma_active,
    input  logic                  sdma_done,
    output logic                  sdma_irq,
    output logic                  ovf,
    output logic                  unf,
    input  logic                  err_clr
);

    localparam logic [AW:0] BURST_LEVEL = (AW+1)'(BURST);

    sdma_state_e state_q, state_d;
    logic        sdma_req_q, sdma_req_d;
    logic        sdma_irq_q, sdma_irq_d;

    sdma_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_data  (data),
        .wr_valid (valid),
        .ready    (ready),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .level    (level),
        .ovf      (ovf),
        .unf      (unf),
        .err_clr  (err_clr)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (level >= BURST_LEVEL) state_d = ST_REQ;
            // A completion that overtakes the accept still finishes the transfer.
            ST_REQ: begin
                if (sdma_done)        state_d = ST_DONE;
                else if (sdma_active) state_d = ST_ACTIVE;
            end
            ST_ACTIVE: if (sdma_done) state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        // Outputs are decoded from the next state so they register on the transition edge.
        sdma_req_d = (state_d == ST_REQ) || (state_d == ST_ACTIVE);
        sdma_irq_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            sdma_req_q <= 1'b0;
            sdma_irq_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sdma_req_q <= sdma_req_d;
            sdma_irq_q <= sdma_irq_d;
        end
    end

    assign sdma_req = sdma_req_q;
    assign sdma_irq = sdma_irq_q;

endmodule

// File: tb/tb_sdma_stream.sv
// Self-checking bench for sdma_stream: a data scoreboard plus a cycle model
// of level, error flags and the request FSM, with directed spot checks.
module tb_sdma_stream;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int BURST = 4;
    localparam int AW    = $clog2(DEPTH);

    localparam int S_IDLE = 0, S_REQ = 1, S_ACT = 2, S_DONE = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] data = '0;
    logic          valid = 1'b0;
    logic          ready;
    logic          rd_en = 1'b0;
    logic [DW-1:0] rd_data;
    logic [AW:0]   level;
    logic          sdma_req;
    logic          sdma_active = 1'b0;
    logic          sdma_done = 1'b0;
    logic          sdma_irq;
    logic          ovf, unf;
    logic          err_clr = 1'b0;

    sdma_stream #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .BURST(BURST)) dut (
        .clk         (clk),
        .rst         (rst),
        .data        (data),
        .valid       (valid),
        .ready       (ready),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .level       (level),
        .sdma_req    (sdma_req),
        .sdma_active (sdma_active),
        .sdma_done   (sdma_done),
        .sdma_irq    (sdma_irq),
        .ovf         (ovf),
        .unf         (unf),
        .err_clr     (err_clr)
    );

    always #5 clk = ~clk;

    int            n_vec  = 0;
    int            n_miss = 0;
    logic [DW-1:0] sb[$];
    int            m_level = 0;
    int            m_st    = S_IDLE;
    logic [DW-1:0] m_rd    = '0;
    logic          m_ovf   = 1'b0;
    logic          m_unf   = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".rd_data"}, rd_data, m_rd);
        check({tag, ".level"}, 32'(level), 32'(m_level));
        check({tag, ".ready"}, 32'(ready), 32'(m_level != DEPTH));
        check({tag, ".req"}, 32'(sdma_req), 32'(m_st == S_REQ || m_st == S_ACT));
        check({tag, ".irq"}, 32'(sdma_irq), 32'(m_st == S_DONE));
        check({tag, ".ovf"}, 32'(ovf), 32'(m_ovf));
        check({tag, ".unf"}, 32'(unf), 32'(m_unf));
    endtask

    // One clock of stimulus; the model advances from pre-edge values.
    task automatic cycle(input string tag, input logic v, input logic [DW-1:0] d,
                         input logic r, input logic act, input logic done, input logic clr);
        bit push_ok, pop_ok;
        valid = v; data = d; rd_en = r; sdma_active = act; sdma_done = done; err_clr = clr;
        push_ok = v && (m_level != DEPTH);
        pop_ok  = r && (m_level != 0);
        if (pop_ok) m_rd = sb.pop_front();
        if (push_ok) sb.push_back(d);
        if (clr) begin m_ovf = 1'b0; m_unf = 1'b0; end
        if (v && m_level == DEPTH) m_ovf = 1'b1;
        if (r && m_level == 0) m_unf = 1'b1;
        case (m_st)
            S_IDLE:  if (m_level >= BURST) m_st = S_REQ;
            S_REQ:   if (done) m_st = S_DONE; else if (act) m_st = S_ACT;
            S_ACT:   if (done) m_st = S_DONE;
            default: m_st = S_IDLE;
        endcase
        m_level = m_level + int'(push_ok) - int'(pop_ok);
        step();
        check_all(tag);
        valid = 1'b0; rd_en = 1'b0; sdma_done = 1'b0; err_clr = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0; valid = 1'b0; rd_en = 1'b0; sdma_done = 1'b0; err_clr = 1'b0;
        step();
        sb.delete();
        m_level = 0; m_st = S_IDLE; m_rd = '0; m_ovf = 1'b0; m_unf = 1'b0;
        check_all("reset");
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        do_reset();
        do_reset();

        // Burst of four words triggers the request, then the DMA drains them.
        for (int i = 0; i < 4; i++) cycle("push42", 1'b1, 32'h11 + i, 1'b0, 1'b0, 1'b0, 1'b0);
        check("lvl42", 32'(level), 32'd4);
        check("req42_pre", 32'(sdma_req), 32'd0);
        cycle("arm42", 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("req42", 32'(sdma_req), 32'd1);
        for (int i = 0; i < 4; i++) begin
            cycle("pop42", 1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
            check("rd42", rd_data, 32'h11 + i);
        end
        cycle("done43", 1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("req43", 32'(sdma_req), 32'd0);
        check("irq43", 32'(sdma_irq), 32'd1);
        cycle("idle43", 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("irq43_off", 32'(sdma_irq), 32'd0);
        cycle("done_idle", 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("irq_idle", 32'(sdma_irq), 32'd0);

        // Overflow: the 17th word is refused and the error sticks.
        for (int i = 0; i < 17; i++) cycle("push44", 1'b1, 32'h100 + i, 1'b0, 1'b0, 1'b0, 1'b0);
        check("ready44", 32'(ready), 32'd0);
        check("ovf44", 32'(ovf), 32'd1);
        for (int i = 0; i < 16; i++) cycle("drain44", 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("last44", rd_data, 32'h10f);
        cycle("unf44", 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("unf44", 32'(unf), 32'd1);
        cycle("clr44", 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("ovf44_clr", 32'(ovf), 32'd0);
        cycle("done44", 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle("idle44", 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Streaming at level 2 across pointer wrap.
        for (int i = 0; i < 2; i++) cycle("fill45", 1'b1, 32'h200 + i, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) cycle("flow45", 1'b1, 32'h202 + i, 1'b1, 1'b0, 1'b0, 1'b0);
        check("lvl45", 32'(level), 32'd2);
        check("rd45", rd_data, 32'h227);
        for (int i = 0; i < 2; i++) cycle("drain45", 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Words left behind re-arm the request after the interrupt.
        for (int i = 0; i < 6; i++) cycle("push46", 1'b1, 32'h300 + i, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle("act46", 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle("done46", 1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("irq46", 32'(sdma_irq), 32'd1);
        cycle("idle46", 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("req46_idle", 32'(sdma_req), 32'd0);
        cycle("rearm46", 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("req46", 32'(sdma_req), 32'd1);

        // Reset in the middle of a transfer.
        cycle("act47", 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle("pop47", 1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("lvl47", 32'(level), 32'd5);
        do_reset();
        check("req47", 32'(sdma_req), 32'd0);
        check("irq47", 32'(sdma_irq), 32'd0);
        cycle("unf47", 1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("unf47", 32'(unf), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
